bayer_img_server: RTL and testbench

Memory-side responder for the 5x5 ACPI demosaic engine's two memory ports. Holds a 128x128 Bayer source image, serves the engine's pixel reads over the bayer_addr/bayer_req/bayer_ready/bayer_data port, and captures the engine's interpolated output writes over the acpi_addr/acpi_valid/acpi_data port into a result buffer. It also tracks image load, serving and completion state. It sits between the testbench/host loader and the demosaic engine.

---
 rtl/bayer_img_server.sv | 157 +++++++++++++++
 tb/tb_bayer_img_server.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bayer_img_server.sv
// Memory-side responder for the demosaic engine: holds the Bayer source image,
// serves pixel reads, captures interpolated results and tracks LOAD/SERVE/DONE.
module bayer_img_server #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDRESS    = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  img_wr_en,
    input  logic [DATA_WIDTH-1:0] img_wr_data,
    input  logic                  restart,
    input  logic [ADDRESS-1:0]    bayer_addr,
    input  logic                  bayer_req,
    output logic                  bayer_ready,
    output logic [DATA_WIDTH-1:0] bayer_data,
    input  logic [ADDRESS-1:0]    acpi_addr,
    input  logic                  acpi_valid,
    input  logic [DATA_WIDTH-1:0] acpi_data,
    input  logic                  finish,
    input  logic [ADDRESS-1:0]    res_rd_addr,
    output logic [DATA_WIDTH-1:0] res_rd_data,
    output logic                  img_loaded,
    output logic                  done,
    output logic [ADDRESS:0]      result_count,
    output logic                  proto_err
);

    localparam int DEPTH = 2 ** ADDRESS;
    localparam logic [ADDRESS-1:0] LAST_PIX  = '1;
    localparam logic [ADDRESS:0]   COUNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SERVE,
        ST_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDRESS-1:0]      load_ptr_q, load_ptr_d;
    logic [ADDRESS:0]        count_q, count_d;
    logic                    proto_err_q, proto_err_d;
    logic                    ready_q, ready_d;
    logic                    loaded_q, loaded_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   bayer_data_q;
    logic [DATA_WIDTH-1:0]   res_rd_data_q;

    logic [DATA_WIDTH-1:0]   image_q  [DEPTH];
    logic [DATA_WIDTH-1:0]   result_q [DEPTH];

    logic                    img_write;
    logic                    res_write;
    logic                    serve_read;

    assign img_write  = (state_q == ST_LOAD)  && img_wr_en;
    assign res_write  = (state_q == ST_SERVE) && acpi_valid;
    assign serve_read = (state_q == ST_SERVE) && bayer_req;

    always_comb begin
        state_d     = state_q;
        load_ptr_d  = load_ptr_q;
        count_d     = count_q;
        proto_err_d = proto_err_q;
        unique case (state_q)
            ST_LOAD: begin
                if (img_wr_en) begin
                    load_ptr_d = load_ptr_q + 1'b1;
                    if (load_ptr_q == LAST_PIX) begin
                        state_d = ST_SERVE;
                    end
                end
                if (bayer_req || acpi_valid) begin
                    proto_err_d = 1'b1;
                end
            end
            ST_SERVE: begin
                if (acpi_valid && (count_q != COUNT_MAX)) begin
                    count_d = count_q + 1'b1;
                end
                if (finish) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bayer_req || acpi_valid) begin
                    proto_err_d = 1'b1;
                end
                if (restart) begin
                    state_d    = ST_LOAD;
                    load_ptr_d = '0;
                    count_d    = '0;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
        // Status flags are decoded from the next state so they register in step with it.
        ready_d  = (state_d == ST_SERVE);
        loaded_d = (state_d != ST_LOAD);
        done_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            load_ptr_q  <= '0;
            count_q     <= '0;
            proto_err_q <= 1'b0;
            ready_q     <= 1'b0;
            loaded_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_ptr_q  <= load_ptr_d;
            count_q     <= count_d;
            proto_err_q <= proto_err_d;
            ready_q     <= ready_d;
            loaded_q    <= loaded_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bayer_data_q  <= '0;
            res_rd_data_q <= '0;
        end else begin
            if (serve_read) begin
                bayer_data_q <= image_q[bayer_addr];
            end
            res_rd_data_q <= result_q[res_rd_addr];
        end
    end

    // Storage arrays carry no reset so image and results survive reset and restart.
    always_ff @(posedge clk) begin
        if (!rst && img_write) begin
            image_q[load_ptr_q] <= img_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && res_write) begin
            result_q[acpi_addr] <= acpi_data;
        end
    end

    assign bayer_ready  = ready_q;
    assign bayer_data   = bayer_data_q;
    assign res_rd_data  = res_rd_data_q;
    assign img_loaded   = loaded_q;
    assign done         = done_q;
    assign result_count = count_q;
    assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_bayer_img_server.sv
// Self-checking bench for bayer_img_server: directed protocol steps plus
// randomized serve traffic checked against an array-based reference model.
module tb_bayer_img_server;

    localparam int DW   = 8;
    localparam int AW   = 14;
    localparam int NPIX = 16384;

    logic            clk = 1'b0;
    logic            rst;
    logic            img_wr_en;
    logic [DW-1:0]   img_wr_data;
    logic            restart;
    logic [AW-1:0]   bayer_addr;
    logic            bayer_req;
    logic            bayer_ready;
    logic [DW-1:0]   bayer_data;
    logic [AW-1:0]   acpi_addr;
    logic            acpi_valid;
    logic [DW-1:0]   acpi_data;
    logic            finish;
    logic [AW-1:0]   res_rd_addr;
    logic [DW-1:0]   res_rd_data;
    logic            img_loaded;
    logic            done;
    logic [AW:0]     result_count;
    logic            proto_err;

    logic [DW-1:0]   imgM [NPIX];
    logic [DW-1:0]   resM [NPIX];
    bit              resKnown [NPIX];
    int              cntM;
    logic [DW-1:0]   bdExp;
    int              compared;
    int              mismatched;

    bayer_img_server #(.DATA_WIDTH(DW), .ADDRESS(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .img_wr_en    (img_wr_en),
        .img_wr_data  (img_wr_data),
        .restart      (restart),
        .bayer_addr   (bayer_addr),
        .bayer_req    (bayer_req),
        .bayer_ready  (bayer_ready),
        .bayer_data   (bayer_data),
        .acpi_addr    (acpi_addr),
        .acpi_valid   (acpi_valid),
        .acpi_data    (acpi_data),
        .finish       (finish),
        .res_rd_addr  (res_rd_addr),
        .res_rd_data  (res_rd_data),
        .img_loaded   (img_loaded),
        .done         (done),
        .result_count (result_count),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearStrobes();
        img_wr_en  = 1'b0;
        bayer_req  = 1'b0;
        acpi_valid = 1'b0;
        finish     = 1'b0;
        restart    = 1'b0;
    endtask

    // mode 0 loads (addr mod 256), mode 1 loads random pixels
    task automatic loadImage(input int mode);
        for (int i = 0; i < NPIX; i++) begin
            img_wr_en   = 1'b1;
            img_wr_data = (mode == 0) ? DW'(i % 256) : DW'($urandom);
            imgM[i]     = img_wr_data;
            if (i == NPIX - 1) begin
                checkOutput("loaded_before_last", {31'd0, img_loaded}, 32'd0);
            end
            step();
        end
        img_wr_en = 1'b0;
        checkOutput("loaded_after_last", {31'd0, img_loaded}, 32'd1);
        checkOutput("ready_after_last", {31'd0, bayer_ready}, 32'd1);
    endtask

    task automatic applyStimulus(input int cycles);
        logic [DW-1:0] expRd;
        bit            rdKnown;
        for (int n = 0; n < cycles; n++) begin
            bayer_req   = 1'($urandom_range(0, 1));
            bayer_addr  = AW'($urandom_range(0, NPIX - 1));
            acpi_valid  = 1'($urandom_range(0, 1));
            acpi_addr   = AW'($urandom_range(0, 63));
            acpi_data   = DW'($urandom);
            res_rd_addr = AW'($urandom_range(0, 63));
            expRd   = resM[res_rd_addr];
            rdKnown = resKnown[res_rd_addr];
            if (bayer_req) bdExp = imgM[bayer_addr];
            if (acpi_valid) begin
                resM[acpi_addr]     = acpi_data;
                resKnown[acpi_addr] = 1'b1;
                cntM++;
            end
            step();
            checkOutput("rand_bayer_data", {24'd0, bayer_data}, {24'd0, bdExp});
            checkOutput("rand_result_count", {17'd0, result_count}, 32'(cntM));
            if (rdKnown) checkOutput("rand_res_rd_data", {24'd0, res_rd_data}, {24'd0, expRd});
        end
        clearStrobes();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        cntM       = 0;
        bdExp      = '0;
        rst        = 1'b1;
        clearStrobes();
        img_wr_data = '0;
        bayer_addr  = '0;
        acpi_addr   = '0;
        acpi_data   = '0;
        res_rd_addr = '0;
        for (int i = 0; i < NPIX; i++) resKnown[i] = 1'b0;
        step();
        step();
        checkOutput("rst_bayer_ready", {31'd0, bayer_ready}, 32'd0);
        checkOutput("rst_bayer_data", {24'd0, bayer_data}, 32'd0);
        checkOutput("rst_res_rd_data", {24'd0, res_rd_data}, 32'd0);
        checkOutput("rst_img_loaded", {31'd0, img_loaded}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_result_count", {17'd0, result_count}, 32'd0);
        checkOutput("rst_proto_err", {31'd0, proto_err}, 32'd0);
        rst = 1'b0;
        step();

        $display("[TB] partial load, protocol error in LOAD, async reset");
        for (int i = 0; i < 100; i++) begin
            img_wr_en   = 1'b1;
            img_wr_data = 8'hEE;
            step();
        end
        img_wr_en  = 1'b0;
        bayer_req  = 1'b1;
        bayer_addr = 14'd5;
        acpi_valid = 1'b1;
        acpi_addr  = 14'd129;
        acpi_data  = 8'h99;
        step();
        clearStrobes();
        checkOutput("load_req_proto_err", {31'd0, proto_err}, 32'd1);
        checkOutput("load_req_bayer_data", {24'd0, bayer_data}, 32'd0);
        checkOutput("load_bayer_ready", {31'd0, bayer_ready}, 32'd0);
        checkOutput("load_valid_count", {17'd0, result_count}, 32'd0);
        step();
        checkOutput("proto_err_sticky", {31'd0, proto_err}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_proto_err", {31'd0, proto_err}, 32'd0);
        step();
        rst = 1'b0;
        step();

        $display("[TB] full load of pattern image");
        loadImage(0);
        checkOutput("after_load_proto_err", {31'd0, proto_err}, 32'd0);
        checkOutput("after_load_done", {31'd0, done}, 32'd0);

        bayer_req  = 1'b1;
        bayer_addr = 14'd0;
        step();
        checkOutput("rd_addr0", {24'd0, bayer_data}, 32'h00);
        bayer_addr = 14'd129;
        step();
        checkOutput("rd_addr129", {24'd0, bayer_data}, 32'h81);
        bayer_addr = 14'd16383;
        step();
        checkOutput("rd_addr16383", {24'd0, bayer_data}, 32'hFF);
        bayer_req  = 1'b0;
        bayer_addr = 14'd7;
        step();
        checkOutput("rd_hold", {24'd0, bayer_data}, 32'hFF);
        bdExp = 8'hFF;

        acpi_valid = 1'b1;
        acpi_addr  = 14'd129;
        acpi_data  = 8'h5A;
        step();
        acpi_data  = 8'h3C;
        step();
        acpi_valid  = 1'b0;
        res_rd_addr = 14'd129;
        step();
        resM[129] = 8'h3C;
        resKnown[129] = 1'b1;
        cntM = 2;
        checkOutput("overwrite_count", {17'd0, result_count}, 32'd2);
        checkOutput("overwrite_readback", {24'd0, res_rd_data}, 32'h3C);

        $display("[TB] randomized serve traffic");
        applyStimulus(300);

        acpi_valid = 1'b1;
        acpi_addr  = 14'd16254;
        acpi_data  = 8'h11;
        finish     = 1'b1;
        step();
        clearStrobes();
        cntM++;
        checkOutput("finish_done", {31'd0, done}, 32'd1);
        checkOutput("finish_ready", {31'd0, bayer_ready}, 32'd0);
        checkOutput("finish_count", {17'd0, result_count}, 32'(cntM));
        checkOutput("finish_loaded", {31'd0, img_loaded}, 32'd1);
        res_rd_addr = 14'd16254;
        step();
        checkOutput("finish_write_kept", {24'd0, res_rd_data}, 32'h11);

        bayer_req   = 1'b1;
        bayer_addr  = 14'd0;
        acpi_valid  = 1'b1;
        acpi_addr   = 14'd129;
        acpi_data   = 8'h77;
        res_rd_addr = 14'd129;
        step();
        clearStrobes();
        checkOutput("done_proto_err", {31'd0, proto_err}, 32'd1);
        checkOutput("done_bayer_hold", {24'd0, bayer_data}, {24'd0, bdExp});
        checkOutput("done_count_hold", {17'd0, result_count}, 32'(cntM));
        step();
        checkOutput("done_write_ignored", {24'd0, res_rd_data}, 32'h3C);

        restart = 1'b1;
        step();
        restart = 1'b0;
        cntM = 0;
        checkOutput("restart_done", {31'd0, done}, 32'd0);
        checkOutput("restart_loaded", {31'd0, img_loaded}, 32'd0);
        checkOutput("restart_ready", {31'd0, bayer_ready}, 32'd0);
        checkOutput("restart_count", {17'd0, result_count}, 32'd0);
        step();
        checkOutput("result_persists", {24'd0, res_rd_data}, 32'h3C);

        $display("[TB] reload with random image");
        loadImage(1);
        applyStimulus(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
